// File: rtl/ssd_hex_display_if.sv
// Host-side bundle for the hex display: capture/control inputs and registered segment outputs.
interface ssd_hex_display_if #(
   parameter int unsigned NUM_DIGITS = 6
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value;
   logic                      lz_suppress;
   logic [NUM_DIGITS-1:0]     blink_mask;
   logic                      blank;
   logic [7*NUM_DIGITS-1:0]   SSD;
   logic [NUM_DIGITS-1:0]     scan_an;
   logic                      loaded;

   modport master (
      output load, value, lz_suppress, blink_mask, blank,
      input  SSD, scan_an, loaded
   );

   modport slave (
      input  load, value, lz_suppress, blink_mask, blank,
      output SSD, scan_an, loaded
   );
endinterface

// File: rtl/ssd_hex_display.sv
// Multi-digit hex to 7-segment driver with leading-zero blanking, per-digit blink,
// global blank and optional time-multiplexed digit scanning.
module ssd_hex_display #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned BLINK_DIV  = 25000000,
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned MUX_MODE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   ssd_hex_display_if.slave  bus
);
   localparam int unsigned DW = 4 * NUM_DIGITS;
   localparam int unsigned OW = 7 * NUM_DIGITS;
   localparam int unsigned BW = $clog2(BLINK_DIV);
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = $clog2(NUM_DIGITS);

   logic [DW-1:0]         disp_q, disp_d;
   logic                  loaded_q;
   logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]         scan_idx_q, scan_idx_d;
   logic [OW-1:0]         ssd_q, ssd_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;

   logic [6:0]            fin [NUM_DIGITS];
   logic                  zero_run;
   logic [3:0]            dig;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0010000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // Timebases: free-running blink divider and (mux mode only) digit scan divider.
   always_comb begin
      disp_d        = bus.load ? bus.value : disp_q;
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;
      scan_cnt_d    = '0;
      scan_idx_d    = '0;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end
      if (MUX_MODE == 1) begin
         scan_cnt_d = scan_cnt_q + SW'(1);
         scan_idx_d = scan_idx_q;
         if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
         end
      end
   end

   // Per-digit final glyph; zero_run tracks "this digit and all above are zero".
   always_comb begin
      fin      = '{default: 7'h7F};
      zero_run = 1'b1;
      dig      = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         dig      = disp_q[4*i +: 4];
         zero_run = zero_run & (dig == 4'd0);
         if (bus.blank)
            fin[i] = 7'h7F;
         else if (blink_phase_q && bus.blink_mask[i])
            fin[i] = 7'h7F;
         else if (bus.lz_suppress && zero_run && (i != 0))
            fin[i] = 7'h7F;
         else
            fin[i] = glyph(dig);
      end
   end

   always_comb begin
      ssd_d = '1;
      an_d  = '1;
      if (MUX_MODE == 1) begin
         ssd_d[6:0]        = fin[scan_idx_q];
         an_d[scan_idx_q]  = 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_DIGITS); i++)
            ssd_d[7*i +: 7] = fin[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q        <= '0;
         loaded_q      <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         scan_cnt_q    <= '0;
         scan_idx_q    <= '0;
         ssd_q         <= '1;
         an_q          <= '1;
      end else begin
         disp_q        <= disp_d;
         loaded_q      <= bus.load;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         scan_cnt_q    <= scan_cnt_d;
         scan_idx_q    <= scan_idx_d;
         ssd_q         <= ssd_d;
         an_q          <= an_d;
      end
   end

   assign bus.SSD     = ssd_q;
   assign bus.scan_an = an_q;
   assign bus.loaded  = loaded_q;
endmodule
